// File: rtl/led_pattern_sequencer_if.sv
// led_pattern_sequencer_if: valid/ready command port of the LED pattern sequencer
interface led_pattern_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             valid;
  logic             ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] data;
  modport master (output valid, op, data, input ready);
  modport slave  (input valid, op, data, output ready);
endinterface

// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: command-driven LED pattern sequencer with rotate/bounce modes, counted or free runs
module led_pattern_sequencer #(
  parameter int                WIDTH        = 16,
  parameter int                RATE_W       = 8,
  parameter logic [RATE_W-1:0] DEFAULT_RATE = 8'd15
) (
  input  logic                   clk_out,
  input  logic                   rst,
  led_pattern_sequencer_if.slave cmd,
  output logic [WIDTH-1:0]       led,
  output logic                   dir_o,
  output logic                   busy,
  output logic                   step_tick,
  output logic                   done,
  output logic                   cmd_err
);
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;
  localparam logic [2:0] OP_LOAD = 3'd1, OP_MODE = 3'd2, OP_RATE = 3'd3, OP_START = 3'd4;
  localparam logic [2:0] OP_STOP = 3'd5, OP_PAUSE = 3'd6, OP_RESUME = 3'd7;
  state_e            state, state_d;
  logic [1:0]        mode, mode_d;
  logic [RATE_W-1:0] rate, rate_d, presc, presc_d;
  logic [WIDTH-1:0]  rem, rem_d, led_d, led_bnc;
  logic              dir_d, ready, acc, hold, step, bnc_right, err_d;
  assign cmd.ready = ready;
  assign busy      = state == RUN;
  assign acc       = cmd.valid && ready;
  // STOP/PAUSE landing on a step edge take priority and swallow that step
  assign hold      = acc && busy && (cmd.op == OP_STOP || cmd.op == OP_PAUSE);
  assign step      = busy && presc == rate && !hold;
  assign bnc_right = dir_o ^ (dir_o ? led[0] : led[WIDTH-1]);
  assign led_bnc   = bnc_right ? led >> 1 : led << 1;
  always_comb begin
    state_d = state;
    led_d   = led;
    dir_d   = dir_o;
    mode_d  = mode;
    rate_d  = rate;
    rem_d   = rem;
    presc_d = busy ? (presc == rate ? '0 : presc + 1'b1) : presc;
    err_d   = 1'b0;
    if (step) begin
      led_d   = mode == 2'd0 ? {led[WIDTH-2:0], led[WIDTH-1]} : mode == 2'd1 ? {led[0], led[WIDTH-1:1]} : led_bnc;
      dir_d   = mode == 2'd0 ? 1'b0 : mode == 2'd1 ? 1'b1 : bnc_right;
      rem_d   = rem == '0 ? rem : rem - 1'b1;
      state_d = rem == WIDTH'(1) ? IDLE : RUN;
    end
    if (acc)
      case (cmd.op)
        OP_LOAD:   if (busy) err_d = 1'b1; else led_d = cmd.data;
        OP_MODE:   if (busy || cmd.data[1:0] == 2'd3) err_d = 1'b1;
                   else begin
                     mode_d = cmd.data[1:0];
                     dir_d  = cmd.data[1:0] == 2'd1;
                   end
        OP_RATE:   if (busy) err_d = 1'b1; else rate_d = cmd.data[RATE_W-1:0];
        OP_START:  if (state != IDLE) err_d = 1'b1;
                   else begin
                     rem_d   = cmd.data;
                     presc_d = '0;
                     state_d = RUN;
                   end
        OP_STOP:   if (state == IDLE) err_d = 1'b1; else state_d = IDLE;
        OP_PAUSE:  if (!busy) err_d = 1'b1; else state_d = PAUSE;
        OP_RESUME: if (state != PAUSE) err_d = 1'b1;
                   else begin
                     state_d = RUN;
                     presc_d = '0;
                   end
        default: ;
      endcase
  end
  always_ff @(posedge clk_out or posedge rst)
    if (rst) begin
      state     <= IDLE;
      led       <= WIDTH'(1);
      dir_o     <= 1'b0;
      mode      <= 2'd0;
      rate      <= DEFAULT_RATE;
      rem       <= '0;
      presc     <= '0;
      ready     <= 1'b0;
      step_tick <= 1'b0;
      done      <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      state     <= state_d;
      led       <= led_d;
      dir_o     <= dir_d;
      mode      <= mode_d;
      rate      <= rate_d;
      rem       <= rem_d;
      presc     <= presc_d;
      ready     <= 1'b1;
      step_tick <= step;
      done      <= step && rem == WIDTH'(1);
      cmd_err   <= err_d;
    end
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed commands against a cycle-level behavioural model plus literal spot checks
module tb_led_pattern_sequencer;
  logic        clk_out = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] led;
  logic        dir_o, busy, step_tick, done, cmd_err;
  int          ntests = 0, nfail = 0;
  led_pattern_sequencer_if #(.WIDTH(16)) cmd();
  led_pattern_sequencer #(.WIDTH(16), .RATE_W(8), .DEFAULT_RATE(8'd15)) dut (
    .clk_out(clk_out), .rst(rst), .cmd(cmd), .led(led), .dir_o(dir_o),
    .busy(busy), .step_tick(step_tick), .done(done), .cmd_err(cmd_err)
  );
  always #5 clk_out = ~clk_out;
  // model state: run schedule kept as the absolute edge number of the next step
  logic [15:0] m_led = 16'h0001;
  logic [1:0]  m_mode = 2'd0;
  logic        m_dir = 1'b0, m_tick = 1'b0, m_done = 1'b0, m_err = 1'b0, m_ready = 1'b0;
  int          m_rate = 15, m_rem = 0, m_state = 0, cyc = 0, next_step = 0;
  function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic bit legal(input int st, input int op, input logic [15:0] d);
    logic [7:0] m;
    m = st == 0 ? 8'b0001_1111 : st == 1 ? 8'b0110_0001 : 8'b1010_1111;
    return m[op] && !(op == 2 && d[1:0] == 2'd3);
  endfunction
  function automatic void do_step();
    if (m_mode == 2'd0) begin
      m_led = (m_led << 1) | (m_led >> 15);
      m_dir = 1'b0;
    end else if (m_mode == 2'd1) begin
      m_led = (m_led >> 1) | (m_led << 15);
      m_dir = 1'b1;
    end else begin
      if (!m_dir && m_led[15]) m_dir = 1'b1;
      else if (m_dir && m_led[0]) m_dir = 1'b0;
      m_led = m_dir ? m_led >> 1 : m_led << 1;
    end
  endfunction
  function automatic void model_reset();
    m_led = 16'h0001; m_mode = 2'd0; m_dir = 1'b0; m_rate = 15; m_rem = 0; m_state = 0;
    m_tick = 1'b0; m_done = 1'b0; m_err = 1'b0; m_ready = 1'b0; cyc = 0; next_step = 0;
  endfunction
  function automatic void model_edge(input logic v, input logic [2:0] op, input logic [15:0] d);
    int  st0;
    bit  acc, hold;
    cyc++;
    st0 = m_state;
    acc = v && m_ready;
    hold = acc && st0 == 1 && (op == 3'd5 || op == 3'd6);
    m_tick = 1'b0; m_done = 1'b0; m_err = 1'b0;
    if (st0 == 1 && cyc == next_step && !hold) begin
      do_step();
      m_tick = 1'b1;
      next_step = cyc + m_rate + 1;
      if (m_rem == 1) begin
        m_done = 1'b1;
        m_state = 0;
      end
      if (m_rem != 0) m_rem--;
    end
    if (acc) begin
      if (!legal(st0, int'(op), d)) m_err = 1'b1;
      else
        case (op)
          3'd1: m_led = d;
          3'd2: begin m_mode = d[1:0]; m_dir = d[1:0] == 2'd1; end
          3'd3: m_rate = int'(d[7:0]);
          3'd4: begin m_rem = int'(d); m_state = 1; next_step = cyc + m_rate + 1; end
          3'd5: m_state = 0;
          3'd6: m_state = 2;
          3'd7: begin m_state = 1; next_step = cyc + m_rate + 1; end
          default: ;
        endcase
    end
    m_ready = 1'b1;
  endfunction
  always @(posedge clk_out or posedge rst)
    if (rst) model_reset();
    else model_edge(cmd.valid, cmd.op, cmd.data);
  always @(negedge clk_out) begin
    chk("led", led, m_led);
    chk("dir_o", 16'(dir_o), 16'(m_dir));
    chk("busy", 16'(busy), 16'(m_state == 1));
    chk("step_tick", 16'(step_tick), 16'(m_tick));
    chk("done", 16'(done), 16'(m_done));
    chk("cmd_err", 16'(cmd_err), 16'(m_err));
    chk("cmd_ready", 16'(cmd.ready), 16'(m_ready));
  end
  task automatic send(input logic [2:0] op, input logic [15:0] d);
    @(negedge clk_out);
    cmd.valid = 1'b1; cmd.op = op; cmd.data = d;
    @(negedge clk_out);
    cmd.valid = 1'b0; cmd.op = 3'd0; cmd.data = 16'h0;
  endtask
  initial begin
    cmd.valid = 1'b0; cmd.op = 3'd0; cmd.data = 16'h0;
    repeat (2) @(negedge clk_out);
    chk("rst_led", led, 16'h0001);
    chk("rst_ready", 16'(cmd.ready), 16'h0);
    chk("rst_busy", 16'(busy), 16'h0);
    rst = 1'b0;
    @(negedge clk_out);
    chk("ready_after_rst", 16'(cmd.ready), 16'h1);
    // counted rotate-left, rate 0
    send(3'd3, 16'd0);
    send(3'd4, 16'd4);
    chk("t1_start_led", led, 16'h0001);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_out);
      chk("t1_led", led, 16'h0002 << i);
      chk("t1_tick", 16'(step_tick), 16'h1);
    end
    chk("t1_done", 16'(done), 16'h1);
    chk("t1_busy", 16'(busy), 16'h0);
    // counted rotate-right, rate 2
    send(3'd1, 16'h8001);
    send(3'd2, 16'd1);
    send(3'd3, 16'd2);
    send(3'd4, 16'd2);
    repeat (2) @(negedge clk_out);
    chk("t2_hold", led, 16'h8001);
    @(negedge clk_out);
    chk("t2_led1", led, 16'hC000);
    chk("t2_dir", 16'(dir_o), 16'h1);
    repeat (3) @(negedge clk_out);
    chk("t2_led2", led, 16'h6000);
    chk("t2_done", 16'(done), 16'h1);
    chk("t2_busy", 16'(busy), 16'h0);
    // free-running bounce
    send(3'd1, 16'h4000);
    send(3'd2, 16'd2);
    send(3'd3, 16'd0);
    send(3'd4, 16'd0);
    @(negedge clk_out);
    chk("t3_up", led, 16'h8000);
    @(negedge clk_out);
    chk("t3_turn", led, 16'h4000);
    chk("t3_dir_r", 16'(dir_o), 16'h1);
    repeat (14) @(negedge clk_out);
    chk("t3_bottom", led, 16'h0001);
    @(negedge clk_out);
    chk("t3_back", led, 16'h0002);
    chk("t3_dir_l", 16'(dir_o), 16'h0);
    send(3'd5, 16'd0);
    // pause on a step edge, resume, stop
    send(3'd1, 16'h0001);
    send(3'd2, 16'd0);
    send(3'd3, 16'd3);
    send(3'd4, 16'd0);
    repeat (2) @(negedge clk_out);
    send(3'd6, 16'd0);
    chk("t4_pause_led", led, 16'h0001);
    chk("t4_pause_tick", 16'(step_tick), 16'h0);
    repeat (10) @(negedge clk_out);
    chk("t4_frozen", led, 16'h0001);
    send(3'd7, 16'd0);
    repeat (3) @(negedge clk_out);
    chk("t4_resume_wait", led, 16'h0001);
    @(negedge clk_out);
    chk("t4_resume_step", led, 16'h0002);
    send(3'd5, 16'd0);
    chk("t4_stop_busy", 16'(busy), 16'h0);
    repeat (5) @(negedge clk_out);
    chk("t4_held", led, 16'h0002);
    // illegal commands
    send(3'd3, 16'd1);
    send(3'd4, 16'd0);
    send(3'd3, 16'd7);
    chk("t5_rate_run_err", 16'(cmd_err), 16'h1);
    chk("t5_still_run", 16'(busy), 16'h1);
    @(negedge clk_out);
    chk("t5_err_pulse", 16'(cmd_err), 16'h0);
    send(3'd5, 16'd0);
    send(3'd5, 16'd0);
    chk("t5_stop_idle_err", 16'(cmd_err), 16'h1);
    send(3'd2, 16'd3);
    chk("t5_mode3_err", 16'(cmd_err), 16'h1);
    send(3'd3, 16'd0);
    send(3'd4, 16'd1);
    @(negedge clk_out);
    chk("t5_mode_kept", 16'(done), 16'h1);
    // reset in the middle of a counted run
    send(3'd1, 16'h0001);
    send(3'd4, 16'd5);
    repeat (2) @(negedge clk_out);
    chk("t6_pre", led, 16'h0004);
    #2 rst = 1'b1;
    #1;
    chk("t6_led", led, 16'h0001);
    chk("t6_busy", 16'(busy), 16'h0);
    chk("t6_done", 16'(done), 16'h0);
    chk("t6_ready", 16'(cmd.ready), 16'h0);
    @(negedge clk_out);
    rst = 1'b0;
    #1;
    chk("t6_ready_rel", 16'(cmd.ready), 16'h0);
    @(negedge clk_out);
    chk("t6_ready_up", 16'(cmd.ready), 16'h1);
    repeat (3) @(negedge clk_out);
    chk("t6_idle_led", led, 16'h0001);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Controller that owns the 16-bit LED pattern register and sequences it: left rotate, right rotate or bounce, at a programmable step rate, for a programmed number of steps or free-running. Sits between the board control logic, which issues commands over a valid/ready port, and the LED pins. It runs on the divided clock clk_out and replaces direct shift-register control with a command-driven run/pause/stop state machine.

## Interface
- WIDTH, 16, LED pattern width (all text below assumes 16)
- RATE_W, 8, width of the step-rate register
- DEFAULT_RATE, 8'd15, step rate after reset
- clk_out  in  1  block clock (divided clock); all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge
- cmd_op  in  3  0 NOP, 1 LOAD, 2 SET_MODE, 3 SET_RATE, 4 START, 5 STOP, 6 PAUSE, 7 RESUME
- cmd_data  in  16  operand: pattern (LOAD), mode in [1:0] (SET_MODE), rate in [7:0] (SET_RATE), step count (START)
- led  out  16  current pattern
- dir_o  out  1  current direction, 0 = left (toward bit 15), 1 = right
- busy  out  1  high while in RUN
- step_tick  out  1  one-cycle pulse after each pattern step
- done  out  1  one-cycle pulse after final step of a counted run
- cmd_err  out  1  one-cycle pulse after an accepted but illegal command

## Operation
- States: IDLE, RUN, PAUSE. Reset state IDLE.
- Reset values: led=16'h0001, mode=ROT_L, rate=DEFAULT_RATE, dir_o=0, remaining=0, prescaler=0, busy=0, step_tick=0, done=0, cmd_err=0, cmd_ready=0 while rst high, 1 from first edge after rst release and thereafter.
- Modes: 0 ROT_L: led <= {led[14:0], led[15]}, dir_o=0. 1 ROT_R: led <= {led[0], led[15:1]}, dir_o=1. 2 BOUNCE: dir_o set to 0 on SET_MODE. Step while dir 0: if led[15]=1, dir<=1 and led<=led>>1; else led<=led<<1. Step while dir 1: if led[0]=1, dir<=0 and led<=led<<1; else led<=led>>1. Zero fill. Mode 3 illegal.
- Commands in IDLE: LOAD, SET_MODE, SET_RATE, START, NOP legal; STOP/PAUSE/RESUME -> cmd_err, no effect.
- Commands in RUN: STOP -> IDLE; PAUSE -> PAUSE; NOP legal; all others -> cmd_err, no effect.
- Commands in PAUSE: RESUME -> RUN (prescaler cleared); STOP -> IDLE; LOAD, SET_MODE, SET_RATE legal (applied, state unchanged); START -> cmd_err.
- SET_MODE with cmd_data[1:0]=3 -> cmd_err, mode unchanged.
- START: remaining <= cmd_data, prescaler <= 0, state RUN. remaining=0 means free-run.
- Prescaler in RUN counts 0..rate; step occurs at edge where prescaler==rate, prescaler then returns to 0. rate=0 steps every cycle.
- Each step: led/dir update per mode; if remaining!=0, remaining decrements; if remaining was 1, state -> IDLE and done pulses.
- led holds value in IDLE and PAUSE; STOP does not change led.

## Timing
- Command accepted at edge k: state/config change visible after edge k; cmd_err high in cycle k..k+1 only.
- START at edge k with rate R: first led change at edge k+R+1, subsequent every R+1 edges.
- step_tick registered: high for the cycle following each step edge; done coincides with step_tick of the final step; busy falls at that same edge.
- Counted run of N steps at rate R: done after edge k+N*(R+1).
- Command vs step same edge: command wins; STOP or PAUSE at a step edge suppresses the step (no led change, no step_tick, no done, remaining unchanged).
- RESUME restarts prescaler: next step R+1 edges after RESUME acceptance; remaining preserved across PAUSE.
- rst asserted mid-run: all registers return to reset values immediately, no done pulse.
- remaining is 16 bits; no wrap (never decremented below 1 in counted mode, not decremented when 0).

## Test plan
- Reset, then START count 4, rate 0, mode ROT_L -> led 0002,0004,0008,0010 on 4 consecutive edges; done pulses with 4th step_tick; busy low after.
- LOAD 16'h8001, SET_MODE 1, SET_RATE 2, START 2 -> led C000 at edge k+3, 6000 at k+6, done at k+6.
- LOAD 16'h4000, SET_MODE 2, rate 0, START 0 -> led 8000, then 4000 with dir_o=1, continuing to 0001, then 0002 with dir_o=0.
- START 0, rate 3; PAUSE on a step edge -> no step, led frozen 10 cycles; RESUME -> next step exactly 4 edges later; STOP -> IDLE, led held.
- Illegal ops: SET_RATE during RUN, STOP in IDLE, SET_MODE 3 -> cmd_err one cycle each, rate/mode/state unchanged.
- Assert rst mid counted run (remaining 5) -> led=0001, busy=0, done=0 immediately; cmd_ready 0 until first edge after release.
